// File: rtl/instr_register_pkg.sv
// Shared types for instr_register and the scheduler that owns its write port.
// The scheduler's state type and the queue depth live here so both sides agree.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO,
    PASSA,
    PASSB,
    ADD,
    SUB,
    MULT,
    DIV,
    MOD
  } opcode_t;

  typedef logic signed [31:0] operand_t;

  typedef logic [4:0] address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    operand_t result;
  } instruction_t;

  typedef enum logic {
    INIT,
    RUN
  } sched_state_t;

  localparam int DEPTH = 32;

endpackage

// File: rtl/instr_reg_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at rr_ptr, so that
// requester has top priority and the grant is one-hot (or zero if no request).
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_reg_sched.sv
// Shares instr_register's single write port among NUM_REQ producers, treating the
// register as a circular queue read in order by one consumer; scrubs on reset/flush.
module instr_reg_sched
  import instr_register_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = instr_register_pkg::DEPTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  opcode_t            req_opcode [NUM_REQ],
  input  operand_t           req_op_a   [NUM_REQ],
  input  operand_t           req_op_b   [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready,
  input  logic               rd_ready,
  output logic               rd_valid,
  output instruction_t       rd_data,
  input  logic               flush,
  output logic               busy,
  output logic [5:0]         count,
  output logic               load_en,
  output address_t           write_pointer,
  output address_t           read_pointer,
  output operand_t           operand_a,
  output operand_t           operand_b,
  output opcode_t            opcode,
  input  instruction_t       instruction_word
);

  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW   = $bits(address_t);

  sched_state_t    state, state_d;
  logic [5:0]      scrub_ptr;
  address_t        head, tail;
  logic [RR_W-1:0] rr_ptr, win_idx;
  logic [NUM_REQ-1:0] grant;
  logic            can_grant, xfer, pop, scrub_done;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (RR_W)
  ) u_arb (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .grant  (grant)
  );

  assign scrub_done   = (scrub_ptr == 6'(DEPTH));
  assign xfer         = |(req_valid & req_ready);
  assign pop          = rd_valid && rd_ready;
  assign read_pointer = head;
  assign rd_data      = instruction_word;

  // An issued-but-uncommitted write still occupies a slot, hence count + load_en.
  always_comb begin
    state_d   = state;
    req_ready = '0;
    rd_valid  = 1'b0;
    busy      = 1'b0;
    can_grant = 1'b0;
    case (state)
      INIT: begin
        busy = 1'b1;
        if (scrub_done) state_d = RUN;
      end
      RUN: begin
        can_grant = (count + 6'(load_en)) < 6'(DEPTH);
        if (flush) begin
          state_d = INIT;
        end else begin
          if (can_grant) req_ready = grant;
          rd_valid = (count != '0);
        end
      end
    endcase
  end

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_idx = RR_W'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= INIT;
    else          state <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_en       <= 1'b0;
      write_pointer <= '0;
      operand_a     <= '0;
      operand_b     <= '0;
      opcode        <= ZERO;
      count         <= '0;
      scrub_ptr     <= '0;
      rr_ptr        <= '0;
      head          <= '0;
      tail          <= '0;
    end else begin
      case (state)
        INIT: begin
          if (scrub_done) begin
            load_en <= 1'b0;
          end else begin
            load_en       <= 1'b1;
            write_pointer <= scrub_ptr[AW-1:0];
            opcode        <= ZERO;
            operand_a     <= '0;
            operand_b     <= '0;
            scrub_ptr     <= scrub_ptr + 6'd1;
          end
        end
        RUN: begin
          // A write already issued lands in the register this edge but is not counted.
          if (flush) begin
            load_en   <= 1'b0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            scrub_ptr <= '0;
          end else begin
            load_en <= xfer;
            if (xfer) begin
              write_pointer <= tail;
              opcode        <= req_opcode[win_idx];
              operand_a     <= req_op_a[win_idx];
              operand_b     <= req_op_b[win_idx];
              tail          <= tail + 1'b1;
              if (int'(win_idx) == NUM_REQ - 1) rr_ptr <= '0;
              else                              rr_ptr <= win_idx + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            case ({load_en, pop})
              2'b10:   count <= count + 6'd1;
              2'b01:   count <= count - 6'd1;
              default: count <= count;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_reg_sched.sv
// Directed bench for instr_reg_sched with a behavioural instr_register attached
// to its write/read pins; expected values are hand-computed constants.
module tb_instr_reg_sched;
  import instr_register_pkg::*;

  localparam int NR = 2;
  typedef logic [127:0] v_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [NR-1:0] req_valid;
  opcode_t      req_opcode [NR];
  operand_t     req_op_a   [NR];
  operand_t     req_op_b   [NR];
  logic [NR-1:0] req_ready;
  logic         rd_ready;
  logic         rd_valid;
  instruction_t rd_data;
  logic         flush;
  logic         busy;
  logic [5:0]   count;
  logic         load_en;
  address_t     write_pointer;
  address_t     read_pointer;
  operand_t     operand_a;
  operand_t     operand_b;
  opcode_t      opcode;
  instruction_t instruction_word;

  instruction_t mem [32];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_reg_sched #(.NUM_REQ(NR)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_opcode       (req_opcode),
    .req_op_a         (req_op_a),
    .req_op_b         (req_op_b),
    .req_ready        (req_ready),
    .rd_ready         (rd_ready),
    .rd_valid         (rd_valid),
    .rd_data          (rd_data),
    .flush            (flush),
    .busy             (busy),
    .count            (count),
    .load_en          (load_en),
    .write_pointer    (write_pointer),
    .read_pointer     (read_pointer),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .opcode           (opcode),
    .instruction_word (instruction_word)
  );

  function automatic operand_t alu(opcode_t o, operand_t a, operand_t b);
    case (o)
      ADD:     return a + b;
      SUB:     return a - b;
      default: return '0;
    endcase
  endfunction

  // Behavioural instr_register: registered write, combinational read.
  always @(posedge clk) begin
    if (load_en)
      mem[write_pointer] <= '{opc: opcode, op_a: operand_a, op_b: operand_b,
                              result: alu(opcode, operand_a, operand_b)};
  end
  assign instruction_word = mem[read_pointer];

  function automatic instruction_t mk(opcode_t o, int a, int b, int r);
    return '{opc: o, op_a: operand_t'(a), op_b: operand_t'(b), result: operand_t'(r)};
  endfunction

  task automatic chk(input string tag, input v_t obs, input v_t exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid     = 2'b11;
    req_opcode[0] = ADD; req_op_a[0] = 5; req_op_b[0] = 3;
    req_opcode[1] = SUB; req_op_a[1] = 9; req_op_b[1] = 4;
    rd_ready      = 1'b0;
    flush         = 1'b0;

    // Reset values
    #3;
    chk("rst load_en", v_t'(load_en), v_t'(0));
    chk("rst busy", v_t'(busy), v_t'(1));
    chk("rst count", v_t'(count), v_t'(0));
    chk("rst req_ready", v_t'(req_ready), v_t'(0));
    chk("rst rd_valid", v_t'(rd_valid), v_t'(0));
    chk("rst wp", v_t'(write_pointer), v_t'(0));
    chk("rst rp", v_t'(read_pointer), v_t'(0));
    chk("rst opcode", v_t'(opcode), v_t'(ZERO));
    #9 reset_n = 1'b1;

    // Scrub after reset: 32 issue edges, RUN on edge 33
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("scrub wp", v_t'(write_pointer), v_t'(i));
      chk("scrub load_en", v_t'(load_en), v_t'(1));
      if (i == 0 || i == 31) chk("scrub opcode", v_t'(opcode), v_t'(ZERO));
    end
    chk("scrub busy e32", v_t'(busy), v_t'(1));
    chk("scrub req_ready e32", v_t'(req_ready), v_t'(0));
    tick();
    chk("run busy e33", v_t'(busy), v_t'(0));
    chk("run load_en e33", v_t'(load_en), v_t'(0));
    chk("run count e33", v_t'(count), v_t'(0));
    for (int i = 0; i < 32; i++) chk("scrub loc zero", v_t'(mem[i]), v_t'(0));

    // Alternating grants with both requesters valid
    for (int i = 0; i < 4; i++) begin
      chk("alt req_ready", v_t'(req_ready), (i % 2 == 0) ? v_t'(2'b01) : v_t'(2'b10));
      tick();
      chk("alt wp", v_t'(write_pointer), v_t'(i));
    end
    req_valid = 2'b00;
    tick();
    chk("alt count", v_t'(count), v_t'(4));
    chk("alt load_en", v_t'(load_en), v_t'(0));
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("alt rd_valid", v_t'(rd_valid), v_t'(1));
      chk("alt rd_data", v_t'(rd_data),
          (i % 2 == 0) ? v_t'(mk(ADD, 5, 3, 8)) : v_t'(mk(SUB, 9, 4, 5)));
      tick();
    end
    chk("alt empty rd_valid", v_t'(rd_valid), v_t'(0));
    chk("alt empty count", v_t'(count), v_t'(0));
    rd_ready = 1'b0;

    // Push and pop on the same edge at count=1
    req_opcode[0] = ADD; req_op_a[0] = 1; req_op_b[0] = 2;
    req_valid = 2'b01;
    #1;
    chk("pp req_ready", v_t'(req_ready), v_t'(2'b01));
    tick();
    chk("pp wp1", v_t'(write_pointer), v_t'(4));
    req_valid = 2'b00;
    tick();
    chk("pp count1", v_t'(count), v_t'(1));
    chk("pp head data", v_t'(rd_data), v_t'(mk(ADD, 1, 2, 3)));
    req_opcode[0] = SUB; req_op_a[0] = 7; req_op_b[0] = 2;
    req_valid = 2'b01;
    tick();
    chk("pp wp2", v_t'(write_pointer), v_t'(5));
    chk("pp count pending", v_t'(count), v_t'(1));
    req_valid = 2'b00;
    rd_ready  = 1'b1;
    tick();
    chk("pp count same", v_t'(count), v_t'(1));
    chk("pp rp", v_t'(read_pointer), v_t'(5));
    chk("pp new head", v_t'(rd_data), v_t'(mk(SUB, 7, 2, 5)));
    tick();
    rd_ready = 1'b0;
    chk("pp drained", v_t'(count), v_t'(0));

    // Flush with a write in flight and count=7
    req_opcode[0] = ADD; req_op_a[0] = 5; req_op_b[0] = 3;
    req_valid = 2'b11;
    #1;
    chk("fl first grant", v_t'(req_ready), v_t'(2'b10));
    for (int i = 0; i < 8; i++) tick();
    chk("fl count7", v_t'(count), v_t'(7));
    chk("fl load_en", v_t'(load_en), v_t'(1));
    chk("fl wp", v_t'(write_pointer), v_t'(13));
    flush = 1'b1;
    #1;
    chk("fl req_ready forced", v_t'(req_ready), v_t'(0));
    chk("fl rd_valid forced", v_t'(rd_valid), v_t'(0));
    tick();
    flush = 1'b0;
    req_valid = 2'b01;
    chk("fl count0", v_t'(count), v_t'(0));
    chk("fl busy", v_t'(busy), v_t'(1));
    chk("fl inflight landed", v_t'(mem[13]), v_t'(mk(ADD, 5, 3, 8)));
    for (int i = 1; i <= 33; i++) begin
      if (i == 10) flush = 1'b1;
      tick();
      flush = 1'b0;
      if (i == 20) chk("fl init req_ready", v_t'(req_ready), v_t'(0));
      if (i == 32) chk("fl busy e32", v_t'(busy), v_t'(1));
      if (i == 33) chk("fl busy e33", v_t'(busy), v_t'(0));
    end
    chk("fl loc13 scrubbed", v_t'(mem[13]), v_t'(0));

    // Fill to 32 from requester 0, then wrap after one pop
    for (int i = 0; i < 32; i++) begin
      chk("full rdy", v_t'(req_ready), v_t'(2'b01));
      tick();
      chk("full wp", v_t'(write_pointer), v_t'(i));
    end
    chk("full rdy off", v_t'(req_ready), v_t'(0));
    chk("full count31", v_t'(count), v_t'(31));
    tick();
    chk("full count32", v_t'(count), v_t'(32));
    chk("full load_en", v_t'(load_en), v_t'(0));
    chk("full rdy still off", v_t'(req_ready), v_t'(0));
    chk("full head data", v_t'(rd_data), v_t'(mk(ADD, 5, 3, 8)));
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("full pop count", v_t'(count), v_t'(31));
    chk("full pop rp", v_t'(read_pointer), v_t'(1));
    #1;
    chk("full regrant", v_t'(req_ready), v_t'(2'b01));
    tick();
    req_valid = 2'b00;
    chk("wrap load_en", v_t'(load_en), v_t'(1));
    chk("wrap wp", v_t'(write_pointer), v_t'(0));
    tick();
    chk("wrap count32", v_t'(count), v_t'(32));

    // Asynchronous reset in the middle of a scrub
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("ar busy", v_t'(busy), v_t'(1));
    for (int i = 0; i < 12; i++) tick();
    chk("ar wp11", v_t'(write_pointer), v_t'(11));
    chk("ar load_en pre", v_t'(load_en), v_t'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("ar load_en", v_t'(load_en), v_t'(0));
    chk("ar wp", v_t'(write_pointer), v_t'(0));
    chk("ar busy rst", v_t'(busy), v_t'(1));
    chk("ar count", v_t'(count), v_t'(0));
    chk("ar opcode", v_t'(opcode), v_t'(ZERO));
    #2 reset_n = 1'b1;
    tick();
    chk("ar restart wp0", v_t'(write_pointer), v_t'(0));
    chk("ar restart load_en", v_t'(load_en), v_t'(1));
    tick();
    chk("ar restart wp1", v_t'(write_pointer), v_t'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
